// File: rtl/rr_arb4_if.sv
// Bundles the request, data and grant signals between the requesters and the rr_arb4 arbiter.
// The master side drives requests and data; the slave side (the arbiter) returns the grant, mux select and data output.
interface rr_arb4_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       S0;
  logic       S1;
  logic       y;
  logic       valid;

  modport master (output req, output din,
                  input gnt, input S0, input S1, input y, input valid);
  modport slave  (input req, input din,
                  output gnt, output S0, output S1, output y, output valid);
endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter driving a shared 4:1 channel mux, with a registered channel output.
// Optional macro RR_ARB4_TIMEOUT_EN limits how long one owner may hold the grant to HOLD_MAX cycles.
//
// state | meaning
// IDLE  | no owner, gnt=0, select=00
// BUSY  | one owner, gnt one-hot, select=owner index
module rr_arb4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic     clk,
  input logic     rst_n,
  rr_arb4_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q;
  logic [1:0] owner_q;
  logic [1:0] last_q;
  logic [3:0] gnt_q;
  logic       y_q;
  logic       valid_q;

  logic [1:0] win_idx;
  logic [1:0] idx;
  logic       any_req;
  logic       hand_off;
  logic       go_idle;
  logic       tmo;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_arb4: HOLD_MAX must lie in 1..255");
  end

`ifdef RR_ARB4_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  logic [7:0] cnt_q;
  assign tmo = (state_q == BUSY) && (cnt_q >= HOLD_LIM) && ((bus.req & ~gnt_q) != 4'b0000);
`else
  assign tmo = 1'b0;
`endif

  // Walk from the farthest candidate to the nearest so the nearest set request after last_q wins.
  always_comb begin
    win_idx = last_q + 2'd1;
    idx     = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      idx = last_q + 2'(i);
      if (bus.req[idx]) win_idx = idx;
    end
  end

  assign any_req  = |bus.req;
  assign hand_off = (state_q == IDLE) ? any_req
                                      : ((!bus.req[owner_q] && any_req) || tmo);
  assign go_idle  = (state_q == BUSY) && !any_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
`ifdef RR_ARB4_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      valid_q <= (state_q == BUSY);
      y_q     <= (state_q == BUSY) ? bus.din[owner_q] : 1'b0;
      if (hand_off) begin
        state_q <= BUSY;
        owner_q <= win_idx;
        last_q  <= win_idx;
        gnt_q   <= 4'b0001 << win_idx;
`ifdef RR_ARB4_TIMEOUT_EN
        cnt_q   <= 8'd1;
`endif
      end else if (go_idle) begin
        state_q <= IDLE;
        owner_q <= 2'd0;
        gnt_q   <= 4'b0000;
`ifdef RR_ARB4_TIMEOUT_EN
        cnt_q   <= 8'd0;
`endif
      end
`ifdef RR_ARB4_TIMEOUT_EN
      else if (state_q == BUSY && cnt_q < HOLD_LIM) begin
        cnt_q <= cnt_q + 8'd1;
      end
`endif
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.S0    = owner_q[1];
  assign bus.S1    = owner_q[0];
  assign bus.y     = y_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed vector table, reset/hold sequences and a random run
// compared against a queue-free behavioural round-robin model.
module tb_rr_arb4;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arb4_if bus ();

  rr_arb4 #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       y;
  } vec_t;

  vec_t tbl [19];

  int n_chk  = 0;
  int n_fail = 0;

  int   m_owner;
  int   m_last;
  int   m_held;
  logic m_y;
  logic m_valid;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] gnt, input logic [1:0] sel,
                          input logic valid, input logic y);
    chk({tag, ".gnt"},   {4'b0, bus.gnt}, {4'b0, gnt});
    chk({tag, ".sel"},   {6'b0, bus.S0, bus.S1}, {6'b0, sel});
    chk({tag, ".valid"}, {7'b0, bus.valid}, {7'b0, valid});
    chk({tag, ".y"},     {7'b0, bus.y}, {7'b0, y});
  endtask

  function automatic int rr_next(input logic [3:0] r, input int last, input int skip);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (last + i) % 4;
      if (r[c] && c != skip) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_y     = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    int nxt;
    m_valid = (m_owner >= 0);
    m_y     = (m_owner >= 0) ? d[m_owner] : 1'b0;
    if (m_owner < 0 || !r[m_owner]) begin
      nxt     = rr_next(r, m_last, -1);
      m_owner = nxt;
      if (nxt >= 0) begin
        m_last = nxt;
        m_held = 1;
      end else begin
        m_held = 0;
      end
    end else begin
`ifdef RR_ARB4_TIMEOUT_EN
      nxt = rr_next(r, m_last, m_owner);
      if (m_held >= HOLD && nxt >= 0) begin
        m_owner = nxt;
        m_last  = nxt;
        m_held  = 1;
      end else if (m_held < HOLD) begin
        m_held++;
      end
`else
      m_held = m_held + 1;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [1:0] exp_s;

    tbl[0]  = '{4'b1111, 4'b1010, 4'b0001, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{4'b1111, 4'b1010, 4'b0001, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{4'b1110, 4'b1010, 4'b0010, 2'b01, 1'b1, 1'b0};
    tbl[3]  = '{4'b1110, 4'b1010, 4'b0010, 2'b01, 1'b1, 1'b1};
    tbl[4]  = '{4'b1100, 4'b1010, 4'b0100, 2'b10, 1'b1, 1'b1};
    tbl[5]  = '{4'b0100, 4'b0000, 4'b0100, 2'b10, 1'b1, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1};
    tbl[7]  = '{4'b0000, 4'b0100, 4'b0000, 2'b00, 1'b1, 1'b1};
    tbl[8]  = '{4'b0000, 4'b0100, 4'b0000, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{4'b1000, 4'b1000, 4'b1000, 2'b11, 1'b0, 1'b0};
    tbl[10] = '{4'b1001, 4'b1000, 4'b1000, 2'b11, 1'b1, 1'b1};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0001, 2'b00, 1'b1, 1'b0};
    tbl[12] = '{4'b0011, 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b1};
    tbl[13] = '{4'b0010, 4'b0011, 4'b0010, 2'b01, 1'b1, 1'b1};
    tbl[14] = '{4'b0011, 4'b0011, 4'b0010, 2'b01, 1'b1, 1'b1};
    tbl[15] = '{4'b0101, 4'b0000, 4'b0100, 2'b10, 1'b1, 1'b0};
    tbl[16] = '{4'b0111, 4'b0000, 4'b0100, 2'b10, 1'b1, 1'b0};
    tbl[17] = '{4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b0};
    tbl[18] = '{4'b0010, 4'b0001, 4'b0010, 2'b01, 1'b1, 1'b1};

    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.din = 4'b0000;
    repeat (2) @(negedge clk);
    chk_outs("reset", 4'b0000, 2'b00, 1'b0, 1'b0);

    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      bus.req = tbl[i].req;
      bus.din = tbl[i].din;
      tick();
      chk_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].y);
    end

    // Asynchronous reset while requester 3 owns the channel.
    bus.req = 4'b1000;
    tick();
    chk("pre_rst.gnt", {4'b0, bus.gnt}, 8'h08);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 4'b0000, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b1000;
    tick();
    chk_outs("post_rst", 4'b1000, 2'b11, 1'b0, 1'b0);

    // Two requesters held constantly: hold limit decides whether the grant rotates.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b0011;
    bus.din = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      tick();
`ifdef RR_ARB4_TIMEOUT_EN
      exp_g = (((k / HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      chk($sformatf("hold%0d.gnt", k), {4'b0, bus.gnt}, {4'b0, exp_g});
    end

    // Random traffic against the behavioural model.
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      bus.din = 4'($urandom);
      @(posedge clk);
      model_step(bus.req, bus.din);
      @(negedge clk);
      exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      exp_s = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
      chk_outs($sformatf("rnd%0d", c), exp_g, exp_s, m_valid, m_y);
      chk($sformatf("rnd%0d.onehot", c), {7'b0, ($countones(bus.gnt) <= 1)}, 8'h01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
